// File: rtl/mul_share_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mul_share_pkg
// Purpose : Shared types and constants for the shared-multiplier arbiter.
// Revision: 1.0  initial release
// ============================================================================
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NUM_REQ = 4;
    localparam int STAT_W      = 16;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin pick: first request at or after ptr_i.
// Revision: 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    always_comb begin
        int k;
        k       = 0;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr_i) + i) % NUM_REQ;
            if (!any_o && req_i[k]) begin
                any_o      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = ID_W'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mul_share_arbiter
// Purpose : Round-robin sharing of one registered signed multiplier among
//           NUM_REQ requesters. Optional per-requester completion counters
//           are built when MUL_ARB_STATS_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MUL_LATENCY = 2,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [NUM_REQ-1:0]    reqValid,
    output logic [NUM_REQ-1:0]    reqReady,
    input  logic [NUM_REQ*DATA_W-1:0] reqA,
    input  logic [NUM_REQ*DATA_W-1:0] reqB,
    output logic                  rspValid,
    input  logic                  rspReady,
    output logic [ID_W-1:0]       rspId,
    output logic [2*DATA_W-1:0]   rspProduct,
    output logic [DATA_W-1:0]     mulA,
    output logic [DATA_W-1:0]     mulB,
    output logic                  mulEnableA,
    output logic                  mulEnableB,
    output logic                  mulEnableOut,
    input  logic [2*DATA_W-1:0]   mulProduct,
    output logic                  busy
`ifdef MUL_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STAT_W-1:0] statCount
`endif
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rrPtr_q, rrPtr_d;
    logic [ID_W-1:0]     curId_q, curId_d;
    logic [CNT_W-1:0]    waitCnt_q, waitCnt_d;
    logic                rspValid_q, rspValid_d;
    logic [ID_W-1:0]     rspId_q, rspId_d;
    logic [2*DATA_W-1:0] rspProduct_q, rspProduct_d;

    logic [NUM_REQ-1:0]  gnt_oh;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (reqValid),
        .ptr_i   (rrPtr_q),
        .grant_o (gnt_oh),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            rrPtr_q      <= '0;
            curId_q      <= '0;
            waitCnt_q    <= '0;
            rspValid_q   <= 1'b0;
            rspId_q      <= '0;
            rspProduct_q <= '0;
        end else begin
            state_q      <= state_d;
            rrPtr_q      <= rrPtr_d;
            curId_q      <= curId_d;
            waitCnt_q    <= waitCnt_d;
            rspValid_q   <= rspValid_d;
            rspId_q      <= rspId_d;
            rspProduct_q <= rspProduct_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rrPtr_d      = rrPtr_q;
        curId_d      = curId_q;
        waitCnt_d    = waitCnt_q;
        rspValid_d   = rspValid_q;
        rspId_d      = rspId_q;
        rspProduct_d = rspProduct_q;
        reqReady     = '0;
        mulA         = '0;
        mulB         = '0;
        mulEnableA   = 1'b0;
        mulEnableB   = 1'b0;
        mulEnableOut = 1'b0;

        case (state_q)
            IDLE: begin
                // Gate with resetN so the combinational grant path is quiet during reset.
                if (gnt_any && resetN) begin
                    reqReady   = gnt_oh;
                    mulA       = reqA[int'(gnt_idx)*DATA_W +: DATA_W];
                    mulB       = reqB[int'(gnt_idx)*DATA_W +: DATA_W];
                    mulEnableA = 1'b1;
                    mulEnableB = 1'b1;
                    curId_d    = gnt_idx;
                    rrPtr_d    = ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                mulEnableOut = 1'b1;
                waitCnt_d    = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                mulEnableOut = 1'b1;
                waitCnt_d    = waitCnt_q + CNT_W'(1);
                if (waitCnt_q == CNT_W'(MUL_LATENCY - 1)) begin
                    rspProduct_d = mulProduct;
                    rspId_d      = curId_q;
                    rspValid_d   = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rspValid_q && rspReady) begin
                    rspValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rspValid   = rspValid_q;
    assign rspId      = rspId_q;
    assign rspProduct = rspProduct_q;
    assign busy       = (state_q != IDLE);

`ifdef MUL_ARB_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_REQ];
    logic              rsp_fire;

    assign rsp_fire = (state_q == RESP) && rspValid_q && rspReady;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
        end else if (rsp_fire) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((int'(rspId_q) == i) && (stat_q[i] != {STAT_W{1'b1}}))
                    stat_q[i] <= stat_q[i] + STAT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        assign statCount[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule
`default_nettype wire

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one registered 32x32 signed multiplier (input regs with enableA/enableB, output reg with enableOut) between NUM_REQ requesters. Round-robin arbitration, valid/ready request and response handshakes, and sequencing of the multiplier's enables over a fixed latency. Sits between client datapaths and the single multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand width; product is 2*DATA_W
MUL_LATENCY, 2, cycles from the first enableOut-high edge until the multiplier product is stable (>=1)
ID_W (localparam), $clog2(NUM_REQ), requester index width

Ports:
clk  in  1  clock, rising edge
resetN  in  1  asynchronous active-low reset
reqValid  in  NUM_REQ  per-requester operation request
reqReady  out  NUM_REQ  one-hot accept; at most one bit high
reqA  in  NUM_REQ*DATA_W  packed signed operand A, requester i at [i*DATA_W +: DATA_W]
reqB  in  NUM_REQ*DATA_W  packed signed operand B
rspValid  out  1  result available
rspReady  in  1  consumer accepts result
rspId  out  ID_W  requester index of the result
rspProduct  out  2*DATA_W  signed product
mulA  out  DATA_W  to multiplier a
mulB  out  DATA_W  to multiplier b
mulEnableA  out  1  to multiplier enableA
mulEnableB  out  1  to multiplier enableB
mulEnableOut  out  1  to multiplier enableOut
mulProduct  in  2*DATA_W  from multiplier product
busy  out  1  high in any state except IDLE
statCount  out  NUM_REQ*16  only with MUL_ARB_STATS_EN

Behaviour:
- Reset (async, resetN=0): state=IDLE, rrPtr=0, waitCnt=0. reqReady, rspValid, rspId, rspProduct, mulA, mulB, all mul enables and busy = 0. Takes effect mid-operation as well: any in-flight op and pending response are discarded.
- FSM: IDLE -> LOAD -> WAIT -> RESP -> IDLE.
- IDLE: the grant g is the first asserted reqValid at or after rrPtr, wrapping. If any request is valid:
  - reqReady[g]=1 combinationally.
  - mulA/mulB = reqA/reqB slice g (combinational mux).
  - mulEnableA = mulEnableB = 1.
  - At the edge: the multiplier input regs load, g is stored as curId, rrPtr <= (g+1) mod NUM_REQ, and the state goes to LOAD.
  - With no valid request, all outputs stay idle.
- LOAD: one cycle. Enables A/B = 0, mulEnableOut = 1, waitCnt <= 0. Next state is WAIT.
- WAIT: mulEnableOut = 1 and waitCnt increments each cycle. When waitCnt == MUL_LATENCY-1:
  - rspProduct <= mulProduct, rspId <= curId, rspValid <= 1.
  - Next state is RESP.
- RESP: rspValid, rspId and rspProduct are held stable and mulEnableOut = 0. On rspValid && rspReady the state returns to IDLE and rspValid <= 0.
- Fixed request-accept to rspValid latency: MUL_LATENCY+2 cycles. Peak throughput: one op per MUL_LATENCY+3 cycles.
- No overlap: while not in IDLE, reqReady = 0. A request withdrawn before acceptance is legal.
- Arithmetic: signed two's complement, full 2*DATA_W result with no truncation. The block does not modify the product.
- Simultaneous requests: strict round-robin. A requester just served has the lowest priority next time.
- rspReady held high: RESP lasts exactly one cycle.

Optional Feature:
MUL_ARB_STATS_EN
- Defined: statCount port exists. One 16-bit counter per requester, incremented on each completed response handshake, saturating at 0xFFFF, cleared by reset.
- Undefined: the port and counters are absent, and other behaviour is identical.

Decomposition:
- Package mul_share_pkg holds:
  - state enum {IDLE, LOAD, WAIT, RESP}
  - default DATA_W/NUM_REQ constants
  - STAT_W=16
- Sub-module rr_arbiter (NUM_REQ): inputs req and ptr, output one-hot grant and encoded index. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single request: req0 with A=0x00087234, B=0x00000348 -> rspValid 4 cycles after accept (MUL_LATENCY=2), rspId=0, rspProduct=0x000000001BB6BAA0.
- Signed operands: req2 with A=B=0xFFFFFEFD -> product 0x0000000000010609. Then A=0x00087234, B=0xFFFFFEFD -> 0xFFFFFFFFF7747564.
- Round-robin fairness: all four reqValid held high with rspReady=1 -> grant order 0,1,2,3,0. Each requester's product returns with the matching rspId.
- Response backpressure: rspReady=0 for 10 cycles -> rspValid/rspProduct held stable, reqReady=0 throughout, no new grant until the handshake.
- Reset mid-WAIT: resetN pulsed low -> all outputs 0 immediately. After release, a req1 with A=0x1, B=0x50647236 -> product 0x0000000050647236, rspId=1.
- Zero and stats: A=0, B=0xB887CAAF -> product 0. With MUL_ARB_STATS_EN, statCount[req] counts completed ops exactly; a counter forced to 0xFFFF stays at 0xFFFF.
